rv_transmitter: RTL

- Source end of the 64-bit ready/valid link feeding the systolic MAC array's receive stage.
- Producer logic pushes words with a one-cycle `load` strobe. The block buffers them in a DEPTH-entry FIFO and presents them in order on valid/data_out.
- It holds each word stable until the downstream `ready` accepts it, then pulses `tx_done` one cycle after every accepted beat.

---
 rtl/rv_transmitter_if.sv | 27 ++
 rtl/rv_transmitter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/rv_transmitter_if.sv
// Ready/valid link between the transmitter and the MAC array receive stage.
// Handshake: a beat transfers on every rising clk edge where valid && ready.
// Once valid is high it stays high, with data_out unchanged, until that beat
// transfers; ready may change freely and has no effect while valid is low.
// tx_done pulses for one cycle, one cycle after each transferred beat.
interface rv_transmitter_if #(
    parameter int WIDTH = 64
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic             tx_done;

    modport master (
        output valid,
        output data_out,
        output tx_done,
        input  ready
    );

    modport slave (
        input  valid,
        input  data_out,
        input  tx_done,
        output ready
    );
endinterface

// File: rtl/rv_transmitter.sv
// Source end of the ready/valid link: buffers producer pushes in a DEPTH-entry
// FIFO and presents them in order. The presented word lives in a registered
// copy of the FIFO head so it stays put (and keeps the last sent word) while
// valid is low. The memory keeps every held word, including the presented one.
module rv_transmitter #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    rv_transmitter_if.master         link
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic [AW:0]      cnt;
    logic             pop;
    logic             push_ok;
    logic [WIDTH-1:0] head_next;

    assign pop        = link.valid && link.ready;
    assign push_ok    = load && (!full || pop);
    assign rd_ptr_inc = rd_ptr + AW'(1);

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // Storage write: a push into a full buffer only lands when the head is
    // leaving this cycle, in which case wr_ptr == rd_ptr and the slot is free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (push_ok && !pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (pop && !push_ok) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

    // Next presented word: the following stored word after a pop, the incoming
    // word when the buffer is otherwise running dry, else hold the current one.
    always_comb begin
        head_next = link.data_out;
        if (pop) begin
            if (cnt > (AW+1)'(1)) begin
                head_next = mem[rd_ptr_inc];
            end else if (push_ok) begin
                head_next = data_in;
            end
        end else if (!link.valid && push_ok) begin
            head_next = data_in;
        end
    end

    // Link FSM with registered valid/data_out/tx_done/overflow outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            link.valid    <= 1'b0;
            link.data_out <= '0;
            link.tx_done  <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            link.data_out <= head_next;
            link.tx_done  <= pop;
            overflow      <= load && !push_ok;
            case (state)
                IDLE: begin
                    if (push_ok) begin
                        state      <= SEND;
                        link.valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (pop && (cnt == (AW+1)'(1)) && !push_ok) begin
                        state      <= IDLE;
                        link.valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    link.valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
